jtag_debug_cmd_sync: RTL and testbench

Parametrised system-clock-side command capture block for the Nios II JTAG debug module. It synchronises the virtual-JTAG update strobes (`vs_udr`, `vs_uir`) from the TCK domain and captures the quasi-static shift register and IR into a small command FIFO. It presents each update event to the debug-action decoder through a valid/ready handshake. It replaces single-event direct decoding: back-to-back updates are buffered, and loss is flagged rather than silent.

---
 rtl/jtag_debug_cmd_sync_if.sv | 28 ++
 rtl/jtag_debug_cmd_sync.sv | 120 ++++++++++++
 tb/tb_jtag_debug_cmd_sync.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_debug_cmd_sync_if.sv
// Command handshake between the JTAG capture block and the debug-action decoder.
// master = capture block (drives the head entry), slave = decoder (drives cmd_ready).
interface jtag_debug_cmd_sync_if #(
    parameter int unsigned DATA_W = 38,
    parameter int unsigned IR_W   = 2
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_is_ir;
    logic [IR_W-1:0]   cmd_ir;
    logic [DATA_W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_is_ir,
        output cmd_ir,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_is_ir,
        input  cmd_ir,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/jtag_debug_cmd_sync.sv
// System-clock capture of virtual-JTAG Update-DR/Update-IR events into a small command FIFO,
// presented to the debug-action decoder through a valid/ready handshake.
module jtag_debug_cmd_sync #(
    parameter int unsigned DATA_W      = 38,
    parameter int unsigned IR_W        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vs_udr,
    input  logic                  vs_uir,
    input  logic [IR_W-1:0]       ir_in,
    input  logic [DATA_W-1:0]     sr,
    jtag_debug_cmd_sync_if.master cmd,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    typedef struct packed {
        logic              is_ir;
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
    logic                   udr_dly_q, uir_dly_q;
    logic                   dr_rise, ir_rise;

    entry_t                 mem_q [FIFO_DEPTH];
    entry_t                 push_entry;
    logic [PTR_W-1:0]       wptr_q, rptr_q;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   ir_pend_q, ir_pend_d;
    logic                   overflow_q, overflow_d;
    logic                   push_req, push, pop, full, valid;

    // Flops reset high so a strobe already high at reset release is never seen as a rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync_q <= '1;
            uir_sync_q <= '1;
            udr_dly_q  <= 1'b1;
            uir_dly_q  <= 1'b1;
        end else begin
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_dly_q  <= udr_sync_q[SYNC_STAGES-1];
            uir_dly_q  <= uir_sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        dr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;
        ir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;
    end

    // A DR rise takes the push slot; a coincident IR rise is deferred by one edge.
    always_comb begin
        push_entry    = '0;
        push_entry.ir = ir_in;
        if (dr_rise) begin
            push_entry.data = sr;
        end else begin
            push_entry.is_ir = 1'b1;
        end
        push_req  = dr_rise | ir_rise | ir_pend_q;
        ir_pend_d = dr_rise & ir_rise;
    end

    always_comb begin
        valid      = (level_q != '0);
        full       = (level_q == LVL_W'(FIFO_DEPTH));
        pop        = valid & cmd.cmd_ready;
        push       = push_req & (~full | pop);
        overflow_d = (push_req & full & ~pop) | (overflow_q & ~clr_overflow);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ir_pend_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= push_entry;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            level_q    <= level_d;
            ir_pend_q  <= ir_pend_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        cmd.cmd_valid = valid;
        cmd.cmd_is_ir = mem_q[rptr_q].is_ir;
        cmd.cmd_ir    = mem_q[rptr_q].ir;
        cmd.cmd_data  = mem_q[rptr_q].data;
        fifo_level    = level_q;
        overflow      = overflow_q;
    end

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Bench for jtag_debug_cmd_sync: vector table, directed corner sequences and a randomized
// run checked against a sample-history/queue reference model.
module tb_jtag_debug_cmd_sync;
    localparam int DW    = 38;
    localparam int IW    = 2;
    localparam int SS    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vs_udr = 1'b0;
    logic          vs_uir = 1'b0;
    logic [IW-1:0] ir_in = '0;
    logic [DW-1:0] sr = '0;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    int total = 0;
    int bad   = 0;

    jtag_debug_cmd_sync_if #(.DATA_W(DW), .IR_W(IW)) cmd_if ();

    jtag_debug_cmd_sync #(
        .DATA_W(DW), .IR_W(IW), .SYNC_STAGES(SS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .vs_udr(vs_udr),
        .vs_uir(vs_uir),
        .ir_in(ir_in),
        .sr(sr),
        .cmd(cmd_if.master),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          use_ir;
        logic [IW-1:0] ir;
        logic [DW-1:0] sr;
        logic          exp_is_ir;
        logic [IW-1:0] exp_ir;
        logic [DW-1:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic          is_ir;
        logic [IW-1:0] ir;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model state: strobe sample history (newest first) and the queued commands.
    bit   hu[$];
    bit   hi[$];
    ent_t mq[$];
    bit   m_pend;
    bit   m_ov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_dr(input logic [DW-1:0] v);
        sr     = v;
        vs_udr = 1'b1;
        repeat (2) step();
        vs_udr = 1'b0;
        repeat (2) step();
    endtask

    task automatic pop_one();
        cmd_if.cmd_ready = 1'b1;
        step();
        cmd_if.cmd_ready = 1'b0;
    endtask

    task automatic model_reset();
        hu.delete();
        hi.delete();
        mq.delete();
        for (int i = 0; i <= SS; i++) begin
            hu.push_back(1'b1);
            hi.push_back(1'b1);
        end
        m_pend = 1'b0;
        m_ov   = 1'b0;
    endtask

    // Called with the inputs the DUT is about to sample; leaves the model in its post-edge state.
    task automatic model_edge();
        bit   dr_ev, ir_ev, pop, full, have;
        ent_t e;
        dr_ev = hu[SS-1] && !hu[SS];
        ir_ev = hi[SS-1] && !hi[SS];
        pop   = (mq.size() != 0) && cmd_if.cmd_ready;
        full  = (mq.size() == DEPTH);
        have  = dr_ev || ir_ev || m_pend;
        e.ir  = ir_in;
        if (dr_ev) begin
            e.is_ir = 1'b0;
            e.data  = sr;
        end else begin
            e.is_ir = 1'b1;
            e.data  = '0;
        end
        m_pend = dr_ev && ir_ev;
        if (pop) void'(mq.pop_front());
        if (have && full && !pop) m_ov = 1'b1;
        else if (clr_overflow) m_ov = 1'b0;
        if (have && (!full || pop)) mq.push_back(e);
        hu.push_front(vs_udr);
        void'(hu.pop_back());
        hi.push_front(vs_uir);
        void'(hi.pop_back());
    endtask

    vec_t tbl[6];

    initial begin
        int   u_cnt, i_cnt, rdy_pct;
        logic u_lvl, i_lvl;

        tbl[0] = '{1'b0, 2'b01, 38'h2A_DEAD_BEEF, 1'b0, 2'b01, 38'h2A_DEAD_BEEF};
        tbl[1] = '{1'b1, 2'b11, 38'h3F_FFFF_FFFF, 1'b1, 2'b11, 38'h0};
        tbl[2] = '{1'b0, 2'b10, 38'h3F_FFFF_FFFF, 1'b0, 2'b10, 38'h3F_FFFF_FFFF};
        tbl[3] = '{1'b1, 2'b00, 38'h12_3456_789A, 1'b1, 2'b00, 38'h0};
        tbl[4] = '{1'b0, 2'b00, 38'h0,            1'b0, 2'b00, 38'h0};
        tbl[5] = '{1'b0, 2'b11, 38'h20_0000_0001, 1'b0, 2'b11, 38'h20_0000_0001};

        cmd_if.cmd_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", cmd_if.cmd_valid, 0);
        chk("rst_is_ir", cmd_if.cmd_is_ir, 0);
        chk("rst_ir", cmd_if.cmd_ir, 0);
        chk("rst_data", cmd_if.cmd_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        repeat (4) step();

        // Single events: latency, captured fields, one-cycle pop.
        for (int v = 0; v < 6; v++) begin
            ir_in = tbl[v].ir;
            sr    = tbl[v].sr;
            if (tbl[v].use_ir) vs_uir = 1'b1;
            else vs_udr = 1'b1;
            for (int k = 0; k < SS; k++) begin
                step();
                chk("tbl_early_valid", cmd_if.cmd_valid, 0);
            end
            step();
            chk("tbl_valid", cmd_if.cmd_valid, 1);
            chk("tbl_is_ir", cmd_if.cmd_is_ir, tbl[v].exp_is_ir);
            chk("tbl_ir", cmd_if.cmd_ir, tbl[v].exp_ir);
            chk("tbl_data", cmd_if.cmd_data, tbl[v].exp_data);
            chk("tbl_level", fifo_level, 1);
            vs_udr = 1'b0;
            vs_uir = 1'b0;
            pop_one();
            chk("tbl_pop_valid", cmd_if.cmd_valid, 0);
            chk("tbl_pop_level", fifo_level, 0);
            repeat (3) step();
        end

        // Overflow: five pushes into four entries, head stalls, then drain in order.
        for (int v = 1; v <= 5; v++) pulse_dr(DW'(v));
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        for (int v = 1; v <= 4; v++) begin
            chk("ovf_order", cmd_if.cmd_data, v);
            pop_one();
        end
        chk("ovf_drained", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Full FIFO with a push landing on the same edge as a pop.
        for (int v = 1; v <= 4; v++) pulse_dr(DW'(v));
        chk("full_level", fifo_level, 4);
        sr     = DW'(5);
        vs_udr = 1'b1;
        repeat (SS) step();
        vs_udr           = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        step();
        cmd_if.cmd_ready = 1'b0;
        chk("pp_level", fifo_level, 4);
        chk("pp_ovf", overflow, 0);
        for (int v = 2; v <= 5; v++) begin
            chk("pp_order", cmd_if.cmd_data, v);
            pop_one();
        end
        chk("pp_drained", fifo_level, 0);
        repeat (3) step();

        // Simultaneous DR and IR rise: DR first, IR one edge later.
        ir_in  = 2'b10;
        sr     = 38'h15;
        vs_udr = 1'b1;
        vs_uir = 1'b1;
        repeat (SS + 1) step();
        chk("sim_level1", fifo_level, 1);
        chk("sim_dr_first", cmd_if.cmd_is_ir, 0);
        chk("sim_dr_data", cmd_if.cmd_data, 38'h15);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        step();
        chk("sim_level2", fifo_level, 2);
        pop_one();
        chk("sim_ir_second", cmd_if.cmd_is_ir, 1);
        chk("sim_ir_val", cmd_if.cmd_ir, 2);
        chk("sim_ir_data", cmd_if.cmd_data, 0);
        pop_one();
        chk("sim_drained", fifo_level, 0);
        repeat (3) step();

        // Reset mid-queue with vs_udr held high across release.
        ir_in = 2'b01;
        pulse_dr(38'hA1);
        pulse_dr(38'hA2);
        sr     = 38'hA3;
        vs_udr = 1'b1;
        repeat (SS + 2) step();
        chk("mid_level", fifo_level, 3);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", cmd_if.cmd_valid, 0);
        chk("arst_level", fifo_level, 0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (6) step();
        chk("held_valid", cmd_if.cmd_valid, 0);
        chk("held_level", fifo_level, 0);
        chk("held_data", cmd_if.cmd_data, 0);
        chk("held_ovf", overflow, 0);
        sr     = 38'hB7;
        vs_udr = 1'b0;
        repeat (4) step();
        vs_udr = 1'b1;
        repeat (4) step();
        vs_udr = 1'b0;
        repeat (4) step();
        chk("post_level", fifo_level, 1);
        chk("post_data", cmd_if.cmd_data, 38'hB7);
        pop_one();

        // Randomized run against the reference model.
        reset_n = 1'b0;
        vs_udr  = 1'b0;
        vs_uir  = 1'b0;
        step();
        model_reset();
        reset_n = 1'b1;
        u_lvl = 1'b0;
        i_lvl = 1'b0;
        u_cnt = 0;
        i_cnt = 0;
        for (int n = 0; n < 4000; n++) begin
            rdy_pct = (n < 2000) ? 15 : 70;
            if (u_cnt >= 2 && $urandom_range(0, 3) == 0) begin
                u_lvl = ~u_lvl;
                u_cnt = 1;
            end else u_cnt++;
            if (i_cnt >= 2 && $urandom_range(0, 4) == 0) begin
                i_lvl = ~i_lvl;
                i_cnt = 1;
            end else i_cnt++;
            if (!u_lvl && !i_lvl && u_cnt > SS + 2 && i_cnt > SS + 2) begin
                sr    = {$urandom, $urandom};
                ir_in = IW'($urandom);
            end
            vs_udr           = u_lvl;
            vs_uir           = i_lvl;
            cmd_if.cmd_ready = ($urandom_range(0, 99) < rdy_pct);
            clr_overflow     = ($urandom_range(0, 99) < 3);
            model_edge();
            step();
            chk("rnd_valid", cmd_if.cmd_valid, mq.size() != 0);
            chk("rnd_level", fifo_level, mq.size());
            chk("rnd_ovf", overflow, m_ov);
            if (mq.size() != 0) begin
                chk("rnd_is_ir", cmd_if.cmd_is_ir, mq[0].is_ir);
                chk("rnd_ir", cmd_if.cmd_ir, mq[0].ir);
                chk("rnd_data", cmd_if.cmd_data, mq[0].data);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
